// File: rtl/sha256_core_scheduler_if.sv
// Handshake bundle between miner control, sha256_core_scheduler and the hash core pool.
// Latency: none (wires only).
// Backpressure: none; cores take one-cycle start pulses and answer with one-cycle done pulses.
interface sha256_core_scheduler_if #(
    parameter int NUM_CORES = 4
);
    logic                 start;
    logic [15:0]          num_jobs;
    logic                 busy;
    logic                 done;
    logic [15:0]          jobs_done;
    logic [NUM_CORES-1:0] core_start;
    logic [15:0]          core_job;
    logic [NUM_CORES-1:0] core_done;
    logic [NUM_CORES-1:0] timeout_err;

    // Miner control plus the core pool: drives batch requests and completions
    modport master (
        output start, num_jobs, core_done,
        input  busy, done, jobs_done, core_start, core_job, timeout_err
    );

    // The scheduler itself
    modport slave (
        input  start, num_jobs, core_done,
        output busy, done, jobs_done, core_start, core_job, timeout_err
    );
endinterface

// File: rtl/sha256_core_scheduler.sv
// Dispatches job indices 0..num_jobs-1 to the lowest idle hash core and counts completions; SCHED_WATCHDOG_EN adds per-core timeouts.
// Latency: first core_start one cycle after the accepted start; done two cycles after the last completion is counted.
// Backpressure: a dispatch waits for an idle core (registered busy mask); start is ignored unless idle.
module sha256_core_scheduler #(
    parameter int NUM_CORES      = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   reset_n,
    sha256_core_scheduler_if.slave sched
);
    if (NUM_CORES < 1 || NUM_CORES > 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("sha256_core_scheduler: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, FINISH} state_t;

    state_t               state_q, state_d;
    logic [15:0]          num_jobs_q, next_job_q, jobs_done_q, core_job_q;
    logic [NUM_CORES-1:0] mask_q, core_start_q;
    logic                 busy_q, done_q;

    logic [NUM_CORES-1:0] idle, pick, hit, expire;
    logic [4:0]           retire_cnt;
    logic                 accept, dispatch_en;

    // Lowest idle core, completions landing on a busy core, and the number of jobs retiring this cycle
    always_comb begin
        idle       = ~mask_q;
        pick       = idle & (~idle + NUM_CORES'(1));
        hit        = sched.core_done & mask_q & {NUM_CORES{state_q != IDLE}};
        retire_cnt = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            retire_cnt = retire_cnt + 5'(hit[k] | expire[k]);
        end
    end

`ifdef SCHED_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0]        wd_cnt_q [NUM_CORES];
    logic [NUM_CORES-1:0] err_q;

    // A core expires when its job has been outstanding TIMEOUT_CYCLES cycles without a completion
    always_comb begin
        expire = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            expire[k] = mask_q[k] & ~hit[k] & (wd_cnt_q[k] == CW'(TIMEOUT_CYCLES - 1));
        end
    end

    // Per-core watchdog counters: restart on dispatch, advance while the core holds a job
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_CORES; k++) wd_cnt_q[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_CORES; k++) begin
                if (dispatch_en && pick[k]) begin
                    wd_cnt_q[k] <= '0;
                end else if (mask_q[k]) begin
                    wd_cnt_q[k] <= wd_cnt_q[k] + CW'(1);
                end
            end
        end
    end

    // Sticky timeout flags, cleared when a new batch is accepted
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= '0;
        end else if (accept) begin
            err_q <= '0;
        end else begin
            err_q <= err_q | expire;
        end
    end

    assign sched.timeout_err = err_q;
`else
    // Without the watchdog a hung core simply keeps the batch in DRAIN
    always_comb begin
        expire = '0;
    end

    assign sched.timeout_err = '0;
`endif

    // Batch sequencing: accept in IDLE, one dispatch per cycle, wait for all retirements, pulse done
    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        dispatch_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (sched.start) begin
                    accept  = 1'b1;
                    state_d = (sched.num_jobs == 16'd0) ? FINISH : DISPATCH;
                end
            end
            DISPATCH: begin
                if (next_job_q < num_jobs_q && idle != '0) begin
                    dispatch_en = 1'b1;
                    if (next_job_q + 16'd1 == num_jobs_q) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (jobs_done_q == num_jobs_q) state_d = FINISH;
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Registered outputs, busy mask and batch counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            core_start_q <= '0;
            core_job_q   <= '0;
            mask_q       <= '0;
            num_jobs_q   <= '0;
            next_job_q   <= '0;
            jobs_done_q  <= '0;
        end else begin
            core_start_q <= dispatch_en ? pick : '0;
            done_q       <= (state_q == FINISH);
            if (accept) begin
                busy_q      <= 1'b1;
                num_jobs_q  <= sched.num_jobs;
                next_job_q  <= '0;
                jobs_done_q <= '0;
                mask_q      <= '0;
            end else begin
                if (state_q == FINISH) busy_q <= 1'b0;
                mask_q      <= (mask_q & ~(hit | expire)) | (dispatch_en ? pick : '0);
                jobs_done_q <= jobs_done_q + 16'(retire_cnt);
                if (dispatch_en) begin
                    core_job_q <= next_job_q;
                    next_job_q <= next_job_q + 16'd1;
                end
            end
        end
    end

    assign sched.busy       = busy_q;
    assign sched.done       = done_q;
    assign sched.jobs_done  = jobs_done_q;
    assign sched.core_start = core_start_q;
    assign sched.core_job   = core_job_q;
endmodule

// File: tb/tb_sha256_core_scheduler.sv
// Self-checking bench for sha256_core_scheduler with four cores and the default build.
// Latency: the reference model predicts every output cycle by cycle from the batch rules.
// Backpressure: simulated cores answer after fixed, random or per-core latencies, with stray done pulses.
module tb_sha256_core_scheduler;
    logic clk;
    logic reset_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    sha256_core_scheduler_if #(.NUM_CORES(4)) sif ();

    sha256_core_scheduler #(.NUM_CORES(4), .TIMEOUT_CYCLES(1024)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .sched   (sif.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One idle cycle: nothing moves and the completion count of the last batch holds
    task automatic idle_check(input int exp_jobs);
        @(posedge clk);
        @(negedge clk);
        check("idle_busy", 32'(sif.busy), 0);
        check("idle_done", 32'(sif.done), 0);
        check("idle_core_start", 32'(sif.core_start), 0);
        check("idle_jobs_done", 32'(sif.jobs_done), exp_jobs);
    endtask

    task automatic reset_check();
        check("rst_busy", 32'(sif.busy), 0);
        check("rst_done", 32'(sif.done), 0);
        check("rst_core_start", 32'(sif.core_start), 0);
        check("rst_core_job", 32'(sif.core_job), 0);
        check("rst_jobs_done", 32'(sif.jobs_done), 0);
        check("rst_timeout_err", 32'(sif.timeout_err), 0);
    endtask

    // Runs one batch from the current negedge. Model rules: dispatch from the edge after start,
    // one per edge, job indices in order, lowest core not holding a job before that edge;
    // a done pulse counts only for a core holding a job; done appears two edges after the
    // final completion is counted (one edge after start for an empty batch).
    // lat_mode: 0 fixed latency, 1 random 1..12, 2 per-core table {3,6,1,4}.
    task automatic run_batch(input int n, input int lat_mode, input int fixed_lat,
                             input int max_edges, input bit expect_finish, input int hang_core);
        logic [3:0]  mask;
        logic [3:0]  cd;
        logic [3:0]  exp_start;
        logic [15:0] exp_job;
        int          ret_edge[4];
        int          lat_tab[4];
        int          next_job;
        int          cnt;
        int          done_edge;
        int          lat;
        bit          finished;
        bit          exp_busy;
        bit          picked;

        lat_tab = '{3, 6, 1, 4};
        mask      = '0;
        next_job  = 0;
        cnt       = 0;
        done_edge = (n == 0) ? 1 : -1;
        finished  = 1'b0;
        for (int k = 0; k < 4; k++) ret_edge[k] = -1;

        sif.start     = 1'b1;
        sif.num_jobs  = 16'(n);
        sif.core_done = '0;

        for (int e = 0; e < max_edges; e++) begin
            exp_start = '0;
            exp_job   = '0;
            picked    = 1'b0;
            if (e >= 1 && next_job < n) begin
                for (int k = 0; k < 4; k++) begin
                    if (!picked && !mask[k]) begin
                        picked       = 1'b1;
                        exp_start[k] = 1'b1;
                        exp_job      = 16'(next_job);
                        next_job++;
                        case (lat_mode)
                            0:       lat = fixed_lat;
                            1:       lat = int'($urandom_range(1, 12));
                            default: lat = lat_tab[k];
                        endcase
                        ret_edge[k] = (k == hang_core) ? -1 : e + lat;
                    end
                end
            end
            for (int k = 0; k < 4; k++) begin
                if (sif.core_done[k] && mask[k]) begin
                    mask[k] = 1'b0;
                    cnt++;
                    if (cnt == n) done_edge = e + 2;
                end
            end
            mask     = mask | exp_start;
            exp_busy = (done_edge < 0) || (e < done_edge);

            @(posedge clk);
            @(negedge clk);
            check("core_start", 32'(sif.core_start), 32'(exp_start));
            if (exp_start != '0) check("core_job", 32'(sif.core_job), 32'(exp_job));
            check("jobs_done", 32'(sif.jobs_done), cnt);
            check("done", 32'(sif.done), 32'(e == done_edge));
            check("busy", 32'(sif.busy), 32'(exp_busy));
            check("timeout_err", 32'(sif.timeout_err), 0);

            if (e == done_edge) begin
                finished = 1'b1;
                break;
            end

            // start and num_jobs are noise from here on: the DUT is not idle at the next edge
            sif.start    = ($urandom_range(0, 3) == 0);
            sif.num_jobs = 16'($urandom);
            for (int k = 0; k < 4; k++) begin
                cd[k] = mask[k] ? (ret_edge[k] == e + 1) : ($urandom_range(0, 7) == 0);
            end
            sif.core_done = cd;
        end

        sif.start     = 1'b0;
        sif.num_jobs  = '0;
        sif.core_done = '0;
        if (expect_finish) check("batch_finished", 32'(finished), 1);
        else               check("batch_open", 32'(finished), 0);
    endtask

    task automatic pulse_reset();
        sif.start     = 1'b0;
        sif.core_done = '0;
        reset_n       = 1'b0;
        #1;
        reset_check();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int nj;
        reset_n       = 1'b0;
        sif.start     = 1'b0;
        sif.num_jobs  = '0;
        sif.core_done = '0;
        repeat (3) @(negedge clk);
        reset_check();
        reset_n = 1'b1;
        idle_check(0);

        // four jobs, ten-cycle cores: one dispatch per core on consecutive edges
        run_batch(4, 0, 10, 200, 1'b1, -1);
        idle_check(4);

        // empty batch
        run_batch(0, 0, 1, 20, 1'b1, -1);
        idle_check(0);

        // ten jobs, five-cycle cores: reuse of cores, each index once
        run_batch(10, 0, 5, 300, 1'b1, -1);
        idle_check(10);

        // cores 0 and 2 complete on the same edge; core 0 is the next one reused
        run_batch(5, 2, 0, 200, 1'b1, -1);
        idle_check(5);

        // random batches with random core latencies
        for (int i = 0; i < 6; i++) begin
            nj = int'($urandom_range(1, 25));
            run_batch(nj, 1, 0, 600, 1'b1, -1);
            idle_check(nj);
        end

        // single-cycle cores
        run_batch(7, 0, 1, 200, 1'b1, -1);
        idle_check(7);

        // core 1 never answers: without the watchdog the batch stays open
        run_batch(4, 0, 10, 120, 1'b0, 1);
        pulse_reset();
        run_batch(2, 0, 3, 100, 1'b1, -1);
        idle_check(2);

        // reset while still dispatching, then a clean batch
        run_batch(20, 0, 30, 3, 1'b0, -1);
        pulse_reset();
        run_batch(2, 1, 0, 100, 1'b1, -1);
        idle_check(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sha256_core_scheduler.md
Name: sha256_core_scheduler

Overview:
- Sequences a pool of NUM_CORES identical sha256 hash engines (start/done handshake) through a batch of num_jobs independent jobs, e.g. nonce indices for the bitcoin miner top level.
- Dispatches job indices 0..num_jobs-1 to idle cores, tracks per-core busy, counts completions, and signals batch completion.
- Sits between the miner top-level control and the replicated hash cores; it moves no data, only job indices and handshakes.

Parameters:
- NUM_CORES, 4, number of hash cores managed (1..16).
- TIMEOUT_CYCLES, 1024, per-job watchdog limit in cycles (used only with SCHED_WATCHDOG_EN).

Ports:
- clk  input  1  single clock, all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  begin batch; sampled only in IDLE.
- num_jobs  input  16  batch size; latched when start is accepted.
- busy  output  1  high from accepted start until the done pulse.
- done  output  1  one-cycle pulse at batch completion.
- jobs_done  output  16  completed-job count for the current batch.
- core_start  output  NUM_CORES  one-hot, one-cycle start pulse to core k.
- core_job  output  16  job index for the core pulsed this cycle; valid only while core_start is nonzero.
- core_done  input  NUM_CORES  one-cycle completion pulse from core k.
- timeout_err  output  NUM_CORES  sticky per-core watchdog flag.

Behaviour:
- Reset (async, reset_n=0): state IDLE; busy=0, done=0, core_start=0, core_job=0, jobs_done=0, timeout_err=0, internal busy mask=0, next_job=0. A reset mid-batch abandons the batch; no done pulse is generated.
- States: IDLE, DISPATCH, DRAIN, FINISH.
- IDLE:
  - On start=1 at edge T: latch num_jobs; clear next_job, jobs_done and timeout_err; set busy=1.
  - Go to DISPATCH, or to FINISH if num_jobs==0.
  - start is ignored in every state other than IDLE.
- DISPATCH:
  - Each edge, while next_job<num_jobs and the registered busy mask has a zero bit, pulse core_start[k] for the lowest-index idle k, drive core_job=next_job, set mask[k], and increment next_job.
  - At most one dispatch per cycle. The first core_start is visible in the cycle after the start edge T (edge T+1).
  - When next_job reaches num_jobs, go to DRAIN.
- Completion handling (all states except IDLE):
  - core_done[k] with mask[k]=1 clears mask[k] and increments jobs_done.
  - Several core_done bits in the same cycle each count (popcount add).
  - core_done[k] with mask[k]=0 is ignored.
  - A core that completes at edge E is eligible for re-dispatch no earlier than edge E+1 (selection uses the registered mask).
- DRAIN: when jobs_done==latched num_jobs, go to FINISH.
- FINISH: done=1 for exactly one cycle, busy=0, return to IDLE. jobs_done holds its value until the next accepted start.
- Widths: counters are 16 bits. num_jobs=65535 is legal; no wrap occurs because next_job stops at num_jobs.
- core_start and core_job are registered outputs; there is no combinational path from core_done to core_start.

Optional Feature:
- Macro SCHED_WATCHDOG_EN.
- Defined:
  - Each core has a cycle counter, cleared on its dispatch and incremented while mask[k]=1.
  - On reaching TIMEOUT_CYCLES: set timeout_err[k] (sticky until the next start), clear mask[k], and increment jobs_done so the batch can still finish.
  - A late core_done from that core is then ignored.
- Not defined: no counters are built, timeout_err is tied to 0, and a hung core stalls the batch in DRAIN until reset.

Test Plan:
- NUM_CORES=4, num_jobs=4, each core_done 10 cycles after its start -> core_start pulses 0001, 0010, 0100, 1000 on consecutive cycles with core_job 0..3; done pulses once; jobs_done=4.
- num_jobs=0 -> busy high for 1 cycle; done pulses on the 2nd cycle after start; core_start never asserts.
- num_jobs=10, cores done after 5 cycles -> core_job values 0..9 each issued exactly once; no core started while busy; done pulses once with jobs_done=10.
- core_done on cores 0 and 2 in the same cycle -> jobs_done increases by 2; core 0 is re-dispatched first on the next edge.
- reset_n low mid-DISPATCH -> all outputs return to 0 immediately; a new start with num_jobs=2 runs cleanly.
- SCHED_WATCHDOG_EN, TIMEOUT_CYCLES=20, core 1 never completes, num_jobs=4 -> timeout_err=0010 after 20 cycles; done pulses; jobs_done=4.
